// File: rtl/sysid_pkg.sv
// -----------------------------------------------------------------------------
// sysid_pkg
// Shared definitions for the system-identification register bank:
//   - word-address constants for the fixed part of the register map
//   - bit index of the uptime-support flag inside the VERSION word
//   - the 32-bit register word type
//   - a byte-lane merge helper used by the SCRATCH write path
// -----------------------------------------------------------------------------
package sysid_pkg;

    typedef logic [31:0] sysid_word_t;

    localparam int SYSID_A_ID        = 0;
    localparam int SYSID_A_TIMESTAMP = 1;
    localparam int SYSID_A_VERSION   = 2;
    localparam int SYSID_A_SCRATCH   = 3;
    localparam int SYSID_A_UPTIME_LO = 4;
    localparam int SYSID_A_UPTIME_HI = 5;
    localparam int SYSID_A_NUM_CAPS  = 6;
    localparam int SYSID_A_RSVD      = 7;
    localparam int SYSID_A_CAP0      = 8;

    // VERSION[31] tells software whether the uptime counter exists.
    localparam int SYSID_UPTIME_FLAG = 31;

    // Replace only the byte lanes selected by be; other lanes keep old_w.
    function automatic sysid_word_t apply_byteenable(input sysid_word_t old_w,
                                                     input sysid_word_t new_w,
                                                     input logic [3:0]  be);
        sysid_word_t res;
        res = old_w;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                res[8*b +: 8] = new_w[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sysid_uptime.sv
// -----------------------------------------------------------------------------
// sysid_uptime
// Prescaled 64-bit free-running uptime counter with a high-word shadow.
// The prescaler counts 0..TICK_DIV-1; on its last value it wraps and the
// counter advances by one. A read of the low word (lo_read_pulse) copies the
// current high word into the shadow so a LO-then-HI read pair is coherent.
//
// Ports:
//   clock          in   single clock
//   reset          in   synchronous, active-high reset
//   lo_read_pulse  in   accepted read of UPTIME_LO this cycle
//   uptime_lo      out  live counter bits [31:0]
//   shadow_hi      out  high word captured by the last UPTIME_LO read
// -----------------------------------------------------------------------------
module sysid_uptime
    import sysid_pkg::*;
#(
    parameter int TICK_DIV = 50
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        lo_read_pulse,
    output sysid_word_t uptime_lo,
    output sysid_word_t shadow_hi
);

    // TICK_DIV=1 would give a zero-width prescaler; keep one bit that
    // simply sits at 0 so every clock is a tick.
    localparam int              PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   PS_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [63:0]   cnt_q,   cnt_d;
    sysid_word_t   shadow_q, shadow_d;
    logic          tick;

    // NOTE: every signal written in always_comb gets a value on every path
    // (here by computing it unconditionally); a missing path infers a latch.
    always_comb begin
        tick     = (presc_q == PS_LAST);
        presc_d  = tick ? '0 : presc_q + 1'b1;
        cnt_d    = tick ? cnt_q + 64'd1 : cnt_q;
        // Capture from the pre-increment value so LO and HI match even when
        // the read coincides with a tick.
        shadow_d = lo_read_pulse ? cnt_q[63:32] : shadow_q;
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            presc_q  <= '0;
            cnt_q    <= '0;
            shadow_q <= '0;
        end else begin
            presc_q  <= presc_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
        end
    end

    assign uptime_lo = cnt_q[31:0];
    assign shadow_hi = shadow_q;

endmodule

// File: rtl/sysid_regbank.sv
// -----------------------------------------------------------------------------
// sysid_regbank
// Avalon-MM slave reporting system ID, build timestamp, version, a scratch
// register, an optional 64-bit uptime counter and NUM_CAPS capability words.
// Reads have a fixed latency of one clock; there is no waitrequest.
//
// Build option: define SYSID_UPTIME_EN to include the uptime counter
// (sysid_uptime). Without it, addresses 4 and 5 read 0 and VERSION[31]
// reads 0.
//
// Ports:
//   clock          in   single clock
//   reset          in   synchronous, active-high reset
//   address        in   word address (ADDR_W bits)
//   read           in   read strobe
//   write          in   write strobe (only SCRATCH is writable)
//   writedata      in   write data
//   byteenable     in   write byte lanes
//   readdata       out  registered read data, held between reads
//   readdatavalid  out  one-cycle pulse one clock after each accepted read
//
// ADDR_W must satisfy 2**ADDR_W >= 8 + NUM_CAPS.
// -----------------------------------------------------------------------------
module sysid_regbank
    import sysid_pkg::*;
#(
    parameter sysid_word_t             SYSTEM_ID   = 32'h5D13_F3DD,
    parameter sysid_word_t             TIMESTAMP   = 32'h0,
    parameter sysid_word_t             VERSION     = 32'h0001_0000,
    parameter sysid_word_t             SCRATCH_RST = 32'h0,
    parameter int                      NUM_CAPS    = 4,
    parameter logic [32*NUM_CAPS-1:0]  CAPS        = '0,
    parameter int                      TICK_DIV    = 50,
    parameter int                      ADDR_W      = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    input  logic [3:0]        byteenable,
    output logic [31:0]       readdata,
    output logic              readdatavalid
);

    sysid_word_t readdata_q, readdata_d;
    logic        rdvalid_q;
    sysid_word_t scratch_q, scratch_d;
    sysid_word_t uptime_lo;
    sysid_word_t shadow_hi;
    sysid_word_t version_w;

`ifdef SYSID_UPTIME_EN
    localparam logic UPTIME_PRESENT = 1'b1;

    logic lo_read_pulse;
    assign lo_read_pulse = read && (address == ADDR_W'(SYSID_A_UPTIME_LO));

    sysid_uptime #(
        .TICK_DIV      (TICK_DIV)
    ) u_uptime (
        .clock         (clock),
        .reset         (reset),
        .lo_read_pulse (lo_read_pulse),
        .uptime_lo     (uptime_lo),
        .shadow_hi     (shadow_hi)
    );
`else
    localparam logic UPTIME_PRESENT = 1'b0;

    assign uptime_lo = '0;
    assign shadow_hi = '0;
`endif

    // The uptime flag is owned by the build, not by the VERSION parameter.
    always_comb begin
        version_w                    = VERSION;
        version_w[SYSID_UPTIME_FLAG] = UPTIME_PRESENT;
    end

    // Read mux: reserved and out-of-range addresses fall through to 0.
    always_comb begin
        readdata_d = '0;
        case (address)
            ADDR_W'(SYSID_A_ID):        readdata_d = SYSTEM_ID;
            ADDR_W'(SYSID_A_TIMESTAMP): readdata_d = TIMESTAMP;
            ADDR_W'(SYSID_A_VERSION):   readdata_d = version_w;
            ADDR_W'(SYSID_A_SCRATCH):   readdata_d = scratch_q;
            ADDR_W'(SYSID_A_UPTIME_LO): readdata_d = uptime_lo;
            ADDR_W'(SYSID_A_UPTIME_HI): readdata_d = shadow_hi;
            ADDR_W'(SYSID_A_NUM_CAPS):  readdata_d = sysid_word_t'(NUM_CAPS);
            ADDR_W'(SYSID_A_RSVD):      readdata_d = '0;
            default: begin
                for (int k = 0; k < NUM_CAPS; k++) begin
                    if (address == ADDR_W'(SYSID_A_CAP0 + k)) begin
                        readdata_d = CAPS[32*k +: 32];
                    end
                end
            end
        endcase
    end

    // Writes to any address other than SCRATCH are dropped.
    always_comb begin
        scratch_d = scratch_q;
        if (write && (address == ADDR_W'(SYSID_A_SCRATCH))) begin
            scratch_d = apply_byteenable(scratch_q, writedata, byteenable);
        end
    end

    // A read+write of SCRATCH in one cycle returns the pre-write value because
    // readdata_d is built from scratch_q, which only updates at this edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            readdata_q <= '0;
            rdvalid_q  <= 1'b0;
            scratch_q  <= SCRATCH_RST;
        end else begin
            rdvalid_q <= read;
            if (read) begin
                readdata_q <= readdata_d;
            end
            scratch_q <= scratch_d;
        end
    end

    assign readdata      = readdata_q;
    assign readdatavalid = rdvalid_q;

endmodule

// File: tb/tb_sysid_regbank.sv
// -----------------------------------------------------------------------------
// tb_sysid_regbank
// Directed bench for sysid_regbank. A main instance (TICK_DIV=4, custom
// TIMESTAMP and CAPS) exercises the register map; a second instance
// (TICK_DIV=1) covers the every-clock uptime case and LO/HI coherence.
// Uptime-specific scenarios are built only when SYSID_UPTIME_EN is defined.
// -----------------------------------------------------------------------------
module tb_sysid_regbank;
    import sysid_pkg::*;

    localparam logic [127:0] CAPS_V = {32'h4444_0004, 32'h3333_0003,
                                       32'h2222_0002, 32'h1111_0001};
    localparam logic [31:0]  TS_V   = 32'h6543_2100;
    localparam logic [31:0]  ID_V   = 32'h5D13_F3DD;
`ifdef SYSID_UPTIME_EN
    localparam logic [31:0]  VER_V  = 32'h8001_0000;
`else
    localparam logic [31:0]  VER_V  = 32'h0001_0000;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic [5:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;
    logic        readdatavalid;

    logic [5:0]  address1;
    logic        read1;
    logic        write1;
    logic [31:0] writedata1;
    logic [3:0]  byteenable1;
    logic [31:0] readdata1;
    logic        readdatavalid1;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    sysid_regbank #(
        .TIMESTAMP     (TS_V),
        .NUM_CAPS      (4),
        .CAPS          (CAPS_V),
        .TICK_DIV      (4),
        .ADDR_W        (6)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .address       (address),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .byteenable    (byteenable),
        .readdata      (readdata),
        .readdatavalid (readdatavalid)
    );

    sysid_regbank #(
        .TICK_DIV      (1)
    ) dut1 (
        .clock         (clock),
        .reset         (reset),
        .address       (address1),
        .read          (read1),
        .write         (write1),
        .writedata     (writedata1),
        .byteenable    (byteenable1),
        .readdata      (readdata1),
        .readdatavalid (readdatavalid1)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    task automatic reset_dut();
        reset       = 1'b1;
        read        = 1'b0;
        write       = 1'b0;
        address     = '0;
        writedata   = '0;
        byteenable  = '0;
        read1       = 1'b0;
        write1      = 1'b0;
        address1    = '0;
        writedata1  = '0;
        byteenable1 = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
    endtask

    // Single isolated read: strobe for one cycle, sample at the next negedge.
    task automatic rd(input logic [5:0] a, output logic [31:0] d, output logic v);
        @(negedge clock);
        address = a;
        read    = 1'b1;
        @(negedge clock);
        read = 1'b0;
        d    = readdata;
        v    = readdatavalid;
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clock);
        address    = a;
        writedata  = d;
        byteenable = be;
        write      = 1'b1;
        @(negedge clock);
        write = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic        v;
        reset_dut();
        total++;
        if (readdata !== 32'h0 || readdatavalid !== 1'b0) begin
            bad++;
            $display("FAIL reset_out: got data=%h valid=%b want 0/0", readdata, readdatavalid);
        end
        rd(6'd0, d, v);
        total++;
        if (d !== ID_V || v !== 1'b1) begin
            bad++;
            $display("FAIL id: got %h valid=%b want %h valid=1", d, v, ID_V);
        end
        @(negedge clock);
        total++;
        if (readdatavalid !== 1'b0 || readdata !== ID_V) begin
            bad++;
            $display("FAIL valid_pulse: got valid=%b data=%h want valid=0 data=%h",
                     readdatavalid, readdata, ID_V);
        end
        rd(6'd1, d, v);
        total++;
        if (d !== TS_V || v !== 1'b1) begin
            bad++;
            $display("FAIL timestamp: got %h valid=%b want %h", d, v, TS_V);
        end
        rd(6'd2, d, v);
        total++;
        if (d !== VER_V) begin
            bad++;
            $display("FAIL version: got %h want %h", d, VER_V);
        end
        rd(6'd6, d, v);
        total++;
        if (d !== 32'd4) begin
            bad++;
            $display("FAIL num_caps: got %h want %h", d, 32'd4);
        end
        rd(6'd3, d, v);
        total++;
        if (d !== 32'h0) begin
            bad++;
            $display("FAIL scratch_rst: got %h want 0", d);
        end
    endtask

    task automatic test_scratch();
        logic [31:0] d;
        logic        v;
        // Write then read on the very next cycle.
        @(negedge clock);
        address    = 6'd3;
        writedata  = 32'hAABB_CCDD;
        byteenable = 4'b0101;
        write      = 1'b1;
        @(negedge clock);
        write = 1'b0;
        read  = 1'b1;
        @(negedge clock);
        read = 1'b0;
        total++;
        if (readdata !== 32'h00BB_00DD || readdatavalid !== 1'b1) begin
            bad++;
            $display("FAIL scratch_be: got %h valid=%b want 00bb00dd", readdata, readdatavalid);
        end
        // Same-cycle read and write: read returns the old value.
        @(negedge clock);
        address    = 6'd3;
        writedata  = 32'h1234_5678;
        byteenable = 4'b1111;
        write      = 1'b1;
        read       = 1'b1;
        @(negedge clock);
        write = 1'b0;
        read  = 1'b0;
        total++;
        if (readdata !== 32'h00BB_00DD) begin
            bad++;
            $display("FAIL rw_same_cycle: got %h want 00bb00dd", readdata);
        end
        rd(6'd3, d, v);
        total++;
        if (d !== 32'h1234_5678) begin
            bad++;
            $display("FAIL scratch_full: got %h want 12345678", d);
        end
        wr(6'd3, 32'hFFFF_FFFF, 4'b1000);
        rd(6'd3, d, v);
        total++;
        if (d !== 32'hFF34_5678) begin
            bad++;
            $display("FAIL scratch_msb: got %h want ff345678", d);
        end
    endtask

    task automatic test_dropped_writes();
        logic [31:0] d;
        logic        v;
        wr(6'd0, 32'hFFFF_FFFF, 4'b1111);
        wr(6'd8, 32'hFFFF_FFFF, 4'b1111);
        rd(6'd0, d, v);
        total++;
        if (d !== ID_V) begin
            bad++;
            $display("FAIL ro_id: got %h want %h", d, ID_V);
        end
        rd(6'd8, d, v);
        total++;
        if (d !== 32'h1111_0001) begin
            bad++;
            $display("FAIL ro_cap0: got %h want 11110001", d);
        end
        rd(6'd3, d, v);
        total++;
        if (d !== 32'hFF34_5678) begin
            bad++;
            $display("FAIL scratch_kept: got %h want ff345678", d);
        end
    endtask

    task automatic test_caps();
        logic [31:0] d;
        logic        v;
        logic [31:0] exp_w;
        for (int k = 0; k < 4; k++) begin
            rd(6'(8 + k), d, v);
            exp_w = CAPS_V[32*k +: 32];
            total++;
            if (d !== exp_w) begin
                bad++;
                $display("FAIL cap%0d: got %h want %h", k, d, exp_w);
            end
        end
        rd(6'd7, d, v);
        total++;
        if (d !== 32'h0) begin
            bad++;
            $display("FAIL reserved7: got %h want 0", d);
        end
        rd(6'd12, d, v);
        total++;
        if (d !== 32'h0) begin
            bad++;
            $display("FAIL past_caps12: got %h want 0", d);
        end
        rd(6'd63, d, v);
        total++;
        if (d !== 32'h0 || v !== 1'b1) begin
            bad++;
            $display("FAIL past_caps63: got %h valid=%b want 0 valid=1", d, v);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clock);
        address = 6'd0;
        read    = 1'b1;
        @(negedge clock);
        total++;
        if (readdatavalid !== 1'b1 || readdata !== ID_V) begin
            bad++;
            $display("FAIL b2b_first: got %h valid=%b want %h", readdata, readdatavalid, ID_V);
        end
        address = 6'd2;
        @(negedge clock);
        read = 1'b0;
        total++;
        if (readdatavalid !== 1'b1 || readdata !== VER_V) begin
            bad++;
            $display("FAIL b2b_second: got %h valid=%b want %h", readdata, readdatavalid, VER_V);
        end
        @(negedge clock);
        total++;
        if (readdatavalid !== 1'b0 || readdata !== VER_V) begin
            bad++;
            $display("FAIL b2b_hold: got %h valid=%b want %h valid=0", readdata, readdatavalid, VER_V);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic        v;
        wr(6'd3, 32'h0F0F_0F0F, 4'b1111);
        @(negedge clock);
        address = 6'd0;
        read    = 1'b1;
        @(negedge clock);
        total++;
        if (readdatavalid !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset_read: got valid=%b want 1", readdatavalid);
        end
        // Read still strobed, but reset is high at the next edge.
        reset = 1'b1;
        @(negedge clock);
        total++;
        if (readdatavalid !== 1'b0 || readdata !== 32'h0) begin
            bad++;
            $display("FAIL reset_mid: got valid=%b data=%h want 0/0", readdatavalid, readdata);
        end
        reset = 1'b0;
        read  = 1'b0;
        rd(6'd3, d, v);
        total++;
        if (d !== 32'h0) begin
            bad++;
            $display("FAIL scratch_after_reset: got %h want 0", d);
        end
    endtask

`ifdef SYSID_UPTIME_EN
    task automatic test_uptime();
        logic [31:0] d;
        logic        v;
        reset_dut();
        repeat (40) @(posedge clock);
        @(negedge clock);
        address  = 6'd4;
        read     = 1'b1;
        address1 = 6'd4;
        read1    = 1'b1;
        @(negedge clock);
        read  = 1'b0;
        read1 = 1'b0;
        total++;
        if (readdata !== 32'd10) begin
            bad++;
            $display("FAIL uptime_div4: got %0d want 10", readdata);
        end
        total++;
        if (readdata1 !== 32'd40 || readdatavalid1 !== 1'b1) begin
            bad++;
            $display("FAIL uptime_div1: got %0d valid=%b want 40", readdata1, readdatavalid1);
        end
        // Wrap from all ones: force last prescaler value, release, one tick.
        @(negedge clock);
        force dut.u_uptime.cnt_q   = 64'hFFFF_FFFF_FFFF_FFFF;
        force dut.u_uptime.presc_q = 2'd3;
        @(negedge clock);
        release dut.u_uptime.cnt_q;
        release dut.u_uptime.presc_q;
        rd(6'd4, d, v);
        total++;
        if (d !== 32'h0) begin
            bad++;
            $display("FAIL wrap_lo: got %h want 0", d);
        end
        rd(6'd5, d, v);
        total++;
        if (d !== 32'h0) begin
            bad++;
            $display("FAIL wrap_hi: got %h want 0", d);
        end
    endtask

    task automatic test_coherent();
        @(negedge clock);
        force dut1.u_uptime.cnt_q = 64'h0000_0000_FFFF_FFFF;
        @(negedge clock);
        release dut1.u_uptime.cnt_q;
        // This read coincides with the LO->HI carry.
        address1 = 6'd4;
        read1    = 1'b1;
        @(negedge clock);
        total++;
        if (readdata1 !== 32'hFFFF_FFFF) begin
            bad++;
            $display("FAIL coh_lo: got %h want ffffffff", readdata1);
        end
        address1 = 6'd5;
        @(negedge clock);
        read1 = 1'b0;
        total++;
        if (readdata1 !== 32'h0) begin
            bad++;
            $display("FAIL coh_hi: got %h want 0", readdata1);
        end
        repeat (5) @(negedge clock);
        address1 = 6'd5;
        read1    = 1'b1;
        @(negedge clock);
        read1 = 1'b0;
        total++;
        if (readdata1 !== 32'h0) begin
            bad++;
            $display("FAIL shadow_hold: got %h want 0", readdata1);
        end
        // A fresh LO read now latches the carried high word.
        @(negedge clock);
        address1 = 6'd4;
        read1    = 1'b1;
        @(negedge clock);
        address1 = 6'd5;
        @(negedge clock);
        read1 = 1'b0;
        total++;
        if (readdata1 !== 32'h1) begin
            bad++;
            $display("FAIL shadow_update: got %h want 1", readdata1);
        end
    endtask
`else
    task automatic test_no_uptime();
        logic [31:0] d;
        logic        v;
        rd(6'd4, d, v);
        total++;
        if (d !== 32'h0) begin
            bad++;
            $display("FAIL no_uptime_lo: got %h want 0", d);
        end
        rd(6'd5, d, v);
        total++;
        if (d !== 32'h0) begin
            bad++;
            $display("FAIL no_uptime_hi: got %h want 0", d);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_scratch();
        test_dropped_writes();
        test_caps();
        test_back_to_back();
        test_reset_mid();
`ifdef SYSID_UPTIME_EN
        test_uptime();
        test_coherent();
`else
        test_no_uptime();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sysid_regbank.md
# sysid_regbank

Parametrised system-identification register bank: an Avalon-MM slave that reports system ID, build timestamp, version and a configurable list of capability words. It also provides a writable scratch register and a prescaled 64-bit uptime counter with coherent two-word reads. It sits on the control interconnect beside the CPU and replaces the fixed two-word ID slave. Software uses it to verify the hardware image and to read board-level features.

## Interface
- `SYSTEM_ID`, default 32'h5D13_F3DD: value returned at word 0.
- `TIMESTAMP`, default 32'h0: build time in Unix seconds, returned at word 1.
- `VERSION`, default 32'h0001_0000: major[31:16] / minor[15:0], returned at word 2.
- `SCRATCH_RST`, default 32'h0: reset value of the scratch register.
- `NUM_CAPS`, default 4, range 1..56: number of capability words.
- `CAPS`, default all zeros: packed vector of 32*NUM_CAPS bits. Word k is `CAPS[32k+31:32k]`.
- `TICK_DIV`, default 50, range 1..65535: clocks per uptime tick.
- `ADDR_W`, default 6: word-address width. Must satisfy 2^ADDR_W >= 8+NUM_CAPS.
- `clock` in 1: single clock for all logic.
- `reset` in 1: synchronous, active-high reset.
- `address` in ADDR_W: word address.
- `read` in 1: read strobe.
- `write` in 1: write strobe.
- `writedata` in 32: write data.
- `byteenable` in 4: byte lanes for writes.
- `readdata` out 32: registered read data.
- `readdatavalid` out 1: one-cycle pulse qualifying `readdata`.

## Operation
- Address map:
  - 0 `SYSTEM_ID`
  - 1 `TIMESTAMP`
  - 2 `VERSION`
  - 3 `SCRATCH` (RW)
  - 4 `UPTIME_LO`
  - 5 `UPTIME_HI_SHADOW`
  - 6 `NUM_CAPS`
  - 7 reserved, reads 0
  - 8..8+NUM_CAPS-1 capability words
  - any address past the last capability word reads 0
- Writes only affect `SCRATCH`; lanes are gated by `byteenable`. Writes to any other address are silently dropped.
- Read of 4 returns live uptime[31:0]. In the same edge it latches uptime[63:32] into the shadow register.
- Read of 5 returns the shadow, not the live high word. This makes a LO-then-HI sequence coherent.
- Read of 5 without a prior read of 4 returns the last latched value, or 0 after reset.
- Uptime logic:
  - A prescaler counts 0..TICK_DIV-1 every clock.
  - On reaching TICK_DIV-1 it wraps to 0 and uptime increments by 1.
  - TICK_DIV=1 means uptime increments every clock.
  - Uptime wraps from 2^64-1 to 0 with no flag.
- There is no state machine: read path is a one-stage pipeline; write path is a direct register update.

## Timing
- No waitrequest. Every strobe is accepted in the cycle it is asserted.
- Read latency is exactly 1:
  - `readdata` and `readdatavalid` are valid on the clock after `read`.
  - `readdatavalid` is high for one cycle per accepted read.
  - Back-to-back reads give back-to-back valid pulses.
- `readdata` holds its last value when `readdatavalid`=0.
- Write latency is 1: a SCRATCH write is visible to a read issued on the following cycle.
- Simultaneous `read` and `write` at address 3: the write is performed and the read returns the pre-write value.
- Simultaneous read of 4 and an uptime increment: LO and the shadow are both sampled from the pre-increment value.
- Reset values:
  - `readdata`=0, `readdatavalid`=0
  - SCRATCH=`SCRATCH_RST`
  - uptime=0, shadow=0, prescaler=0
- Reset asserted mid-operation: any pending `readdatavalid` is suppressed on the next edge. Strobes are ignored while `reset`=1.

## Configuration
- `SYSID_UPTIME_EN` defined: prescaler, 64-bit counter and shadow are built, and behaviour is as above.
- `SYSID_UPTIME_EN` not defined:
  - No counter or prescaler flops are built.
  - Addresses 4 and 5 read 0.
  - Bit 31 of `VERSION` reads as 0 instead of 1. Software uses this bit to detect uptime support.

## Structure
- Shared package `sysid_pkg`:
  - address constants `SYSID_A_ID`..`SYSID_A_CAP0`
  - `SYSID_UPTIME_FLAG` bit index (31)
  - `sysid_word_t` 32-bit typedef
- One sub-module, `sysid_uptime`. It contains the prescaler, 64-bit counter and shadow, with input `lo_read_pulse` and outputs `uptime_lo` and `shadow_hi`.
- The whole `sysid_uptime` instance is wrapped in `SYSID_UPTIME_EN`.

## Test plan
- After reset, read addresses 0,1,2,6 → 32'h5D13F3DD, TIMESTAMP, 32'h8001_0000 (uptime flag set), 4. Each `readdatavalid` arrives exactly 1 clock after its `read`.
- Write 32'hAABBCCDD to 3 with `byteenable`=4'b0101, starting from SCRATCH_RST=0 → next read returns 32'h00BB00DD. A same-cycle read+write at 3 returns the old value.
- TICK_DIV=1, counter forced to 64'h0000_0000_FFFF_FFFF. Read 4 then 5 → 32'hFFFFFFFF then 32'h0. A later read of 5 without reading 4 still returns 0.
- TICK_DIV=4: run 40 clocks after reset → UPTIME_LO=10. Counter forced to all ones plus one tick → wraps to 0.
- Read addresses 8..11 → CAPS words 0..3. Read 12 and 63 → 0. Writes to 0 and 8 leave their read values unchanged.
- Assert `reset` the cycle after a read → no `readdatavalid`, and SCRATCH returns to SCRATCH_RST. A build without `SYSID_UPTIME_EN` reads 0 at 4 and 5 and 32'h0001_0000 at 2.
